nlm_wacc_div: RTL and testbench

Parametrised NLM weighted-accumulate engine, the multi-lane successor to the single-term PE chain. Each beat accepts LANES (weight, search-pixel) pairs; the block accumulates weight sum and weighted-pixel sum over a runtime-configurable number of beats (one search window). It then optionally normalises the result with a sequential rounding divider. It sits between the NLM weight-generation stage and the output pixel stream, with valid/ready handshakes on both sides.

---
 rtl/nlm_wacc_div.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_nlm_wacc_div.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nlm_wacc_div.sv
// ---------------------------------------------------------------------------
// nlm_wacc_div
//
// Multi-lane NLM weighted-accumulate engine. Each accepted beat carries LANES
// (weight, search-pixel) pairs. Over one search window of cfg_beats beats the
// block accumulates the weight sum and the weighted-pixel sum, then either
// presents the raw sums or first normalises them with a sequential restoring
// divider (rounded psum / wsum, one quotient bit per cycle).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   cfg_beats  in   beats per window (0 -> 1, > MAX_BEATS -> MAX_BEATS),
//                   sampled with the first beat of a window
//   cfg_norm   in   1 = divide, 0 = raw sums only, sampled with first beat
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted when in_valid && in_ready
//   in_weight  in   lane i weight at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   in_pix     in   lane i pixel  at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out  result valid
//   out_ready  in   result consumed when out_valid && out_ready
//   out_wsum   out  window weight sum
//   out_psum   out  window weighted-pixel sum
//   out_pix    out  rounded psum/wsum (0 in raw mode or when wsum = 0)
//   out_zero   out  wsum was 0 in normalised mode
// ---------------------------------------------------------------------------
module nlm_wacc_div #(
  parameter int DATA_WIDTH   = 12,
  parameter int WEIGHT_WIDTH = 8,
  parameter int LANES        = 7,
  parameter int MAX_BEATS    = 7,
  parameter int WSUM_W       = WEIGHT_WIDTH + $clog2(LANES * MAX_BEATS),
  parameter int PSUM_W       = WSUM_W + DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [$clog2(MAX_BEATS+1)-1:0]     cfg_beats,
  input  logic                               cfg_norm,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [LANES*WEIGHT_WIDTH-1:0]      in_weight,
  input  logic [LANES*DATA_WIDTH-1:0]        in_pix,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WSUM_W-1:0]                  out_wsum,
  output logic [PSUM_W-1:0]                  out_psum,
  output logic [DATA_WIDTH-1:0]              out_pix,
  output logic                               out_zero
);

  localparam int CFG_W  = $clog2(MAX_BEATS + 1);
  localparam int DCNT_W = $clog2(DATA_WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [CFG_W-1:0]  BEATS_ONE = CFG_W'(1);
  localparam logic [CFG_W-1:0]  BEATS_MAX = CFG_W'(MAX_BEATS);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
  localparam logic [DCNT_W-1:0] DIV_LAST  = DCNT_W'(DATA_WIDTH - 1);

  // Registered state
  logic [1:0]            state_q,     state_d;
  logic [CFG_W-1:0]      beats_q,     beats_d;
  logic                  norm_q,      norm_d;
  logic [CFG_W-1:0]      cnt_q,       cnt_d;
  logic [WSUM_W-1:0]     wacc_q,      wacc_d;
  logic [PSUM_W-1:0]     pacc_q,      pacc_d;
  logic [WSUM_W-1:0]     rem_q,       rem_d;
  logic [DATA_WIDTH-1:0] quo_q,       quo_d;
  logic [DCNT_W-1:0]     dcnt_q,      dcnt_d;
  logic                  in_ready_q,  in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [WSUM_W-1:0]     out_wsum_q,  out_wsum_d;
  logic [PSUM_W-1:0]     out_psum_q,  out_psum_d;
  logic [DATA_WIDTH-1:0] out_pix_q,   out_pix_d;
  logic                  out_zero_q,  out_zero_d;

  // Combinational helpers
  logic [WSUM_W-1:0]     beat_wsum_s;
  logic [PSUM_W-1:0]     beat_psum_s;
  logic [WSUM_W-1:0]     wacc_sum_s;
  logic [PSUM_W-1:0]     pacc_sum_s;
  logic [PSUM_W-1:0]     num_s;
  logic [CFG_W-1:0]      eff_beats_s;
  logic                  accept_s;
  logic                  last_beat_s;
  logic                  norm_sel_s;
  logic [WSUM_W:0]       trial_s;
  logic                  qbit_s;
  logic [WSUM_W-1:0]     rem_step_s;
  logic [DATA_WIDTH-1:0] quo_step_s;

  // Single-cycle multiply-add tree over all lanes of the current beat.
  always_comb begin
    beat_wsum_s = '0;
    beat_psum_s = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_wsum_s = beat_wsum_s + WSUM_W'(in_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      beat_psum_s = beat_psum_s
                  + (PSUM_W'(in_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH])
                   * PSUM_W'(in_pix[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // Clamp the beat count; the upper clamp only exists when the field can
  // encode more than MAX_BEATS.
  if ((2 ** CFG_W - 1) > MAX_BEATS) begin : g_clamp
    // Zero maps to one beat, oversize maps to MAX_BEATS.
    always_comb begin
      if (cfg_beats == '0) begin
        eff_beats_s = BEATS_ONE;
      end else if (cfg_beats > BEATS_MAX) begin
        eff_beats_s = BEATS_MAX;
      end else begin
        eff_beats_s = cfg_beats;
      end
    end
  end else begin : g_noclamp
    // Zero maps to one beat; every other encoding is already legal.
    always_comb begin
      if (cfg_beats == '0) begin
        eff_beats_s = BEATS_ONE;
      end else begin
        eff_beats_s = cfg_beats;
      end
    end
  end

  // Window bookkeeping: the first beat restarts the sums and uses live cfg,
  // later beats extend the sums and use the values latched at window start.
  always_comb begin
    accept_s = in_valid && in_ready_q;
    if (state_q == ST_IDLE) begin
      wacc_sum_s  = beat_wsum_s;
      pacc_sum_s  = beat_psum_s;
      last_beat_s = (eff_beats_s == BEATS_ONE);
      norm_sel_s  = cfg_norm;
    end else begin
      wacc_sum_s  = wacc_q + beat_wsum_s;
      pacc_sum_s  = pacc_q + beat_psum_s;
      last_beat_s = ((cnt_q + BEATS_ONE) == beats_q);
      norm_sel_s  = norm_q;
    end
    // Rounding bias wsum/2 folded into the numerator; it cannot overflow
    // PSUM_W because psum <= wsum * (2^DATA_WIDTH - 1).
    num_s = pacc_sum_s + PSUM_W'(wacc_sum_s >> 1);
  end

  // One restoring-division step. The remainder starts as num >> DATA_WIDTH,
  // which is always below the divisor, so each step subtracts at most once.
  // quo_q shifts numerator bits out of its MSB and quotient bits into its LSB.
  always_comb begin
    trial_s = {rem_q, quo_q[DATA_WIDTH-1]};
    qbit_s  = (wacc_q != '0) && (trial_s >= {1'b0, wacc_q});
    if (qbit_s) begin
      rem_step_s = WSUM_W'(trial_s - {1'b0, wacc_q});
    end else begin
      rem_step_s = trial_s[WSUM_W-1:0];
    end
    quo_step_s = {quo_q[DATA_WIDTH-2:0], qbit_s};
  end

  // Next-state and output-register logic for the IDLE/ACC/DIV/OUT sequence.
  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    norm_d      = norm_q;
    cnt_d       = cnt_q;
    wacc_d      = wacc_q;
    pacc_d      = pacc_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dcnt_d      = dcnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_wsum_d  = out_wsum_q;
    out_psum_d  = out_psum_q;
    out_pix_d   = out_pix_q;
    out_zero_d  = out_zero_q;

    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (accept_s) begin
          wacc_d = wacc_sum_s;
          pacc_d = pacc_sum_s;
          if (state_q == ST_IDLE) begin
            beats_d = eff_beats_s;
            norm_d  = cfg_norm;
            cnt_d   = BEATS_ONE;
          end else begin
            cnt_d   = cnt_q + BEATS_ONE;
          end
          if (last_beat_s) begin
            in_ready_d = 1'b0;
            if (norm_sel_s) begin
              state_d = ST_DIV;
              rem_d   = num_s[PSUM_W-1:DATA_WIDTH];
              quo_d   = num_s[DATA_WIDTH-1:0];
              dcnt_d  = '0;
            end else begin
              // Raw mode: result is visible on the edge that takes the last beat.
              state_d     = ST_OUT;
              out_valid_d = 1'b1;
              out_wsum_d  = wacc_sum_s;
              out_psum_d  = pacc_sum_s;
              out_pix_d   = '0;
              out_zero_d  = 1'b0;
            end
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_DIV: begin
        rem_d  = rem_step_s;
        quo_d  = quo_step_s;
        dcnt_d = dcnt_q + DCNT_ONE;
        if (dcnt_q == DIV_LAST) begin
          // A zero divisor yields all-zero quotient bits after the same latency.
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
          out_wsum_d  = wacc_q;
          out_psum_d  = pacc_q;
          out_pix_d   = quo_step_s;
          out_zero_d  = (wacc_q == '0);
        end else begin
          state_d = ST_DIV;
        end
      end

      ST_OUT: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = ST_OUT;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beats_q     <= '0;
      norm_q      <= 1'b0;
      cnt_q       <= '0;
      wacc_q      <= '0;
      pacc_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dcnt_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_wsum_q  <= '0;
      out_psum_q  <= '0;
      out_pix_q   <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      norm_q      <= norm_d;
      cnt_q       <= cnt_d;
      wacc_q      <= wacc_d;
      pacc_q      <= pacc_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dcnt_q      <= dcnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_wsum_q  <= out_wsum_d;
      out_psum_q  <= out_psum_d;
      out_pix_q   <= out_pix_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_wsum  = out_wsum_q;
  assign out_psum  = out_psum_q;
  assign out_pix   = out_pix_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_nlm_wacc_div.sv
// ---------------------------------------------------------------------------
// tb_nlm_wacc_div
//
// Self-checking bench for nlm_wacc_div at default parameters. Stimulus is
// driven and outputs are sampled on the falling clock edge. Expected sums,
// rounded quotient and latencies come from plain arithmetic on the beats the
// bench saw accepted.
// ---------------------------------------------------------------------------
module tb_nlm_wacc_div;

  localparam int DW  = 12;
  localparam int WW  = 8;
  localparam int L   = 7;
  localparam int MB  = 7;
  localparam int WSW = 14;
  localparam int PSW = 26;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [CW-1:0]  cfg_beats;
  logic           cfg_norm;
  logic           in_valid;
  logic           in_ready;
  logic [L*WW-1:0] in_weight;
  logic [L*DW-1:0] in_pix;
  logic           out_valid;
  logic           out_ready;
  logic [WSW-1:0] out_wsum;
  logic [PSW-1:0] out_psum;
  logic [DW-1:0]  out_pix;
  logic           out_zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nlm_wacc_div dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_beats (cfg_beats),
    .cfg_norm  (cfg_norm),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_weight (in_weight),
    .in_pix    (in_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wsum  (out_wsum),
    .out_psum  (out_psum),
    .out_pix   (out_pix),
    .out_zero  (out_zero)
  );

  // Count one comparison and report it when observed differs from expected.
  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Lane data: 0 random, 1 full scale, 2 zero weights, 3 rounding pattern.
  task automatic drive_beat(input int wmode);
    for (int i = 0; i < L; i++) begin
      case (wmode)
        1: begin in_weight[i*WW +: WW] = 8'd255; in_pix[i*DW +: DW] = 12'd4095; end
        2: begin in_weight[i*WW +: WW] = 8'd0;   in_pix[i*DW +: DW] = DW'($urandom); end
        3: begin
          in_pix[i*DW +: DW] = DW'($urandom);
          in_weight[i*WW +: WW] = 8'd0;
          if (i == 0) begin in_weight[i*WW +: WW] = 8'd1; in_pix[i*DW +: DW] = 12'd10; end
          if (i == 1) begin in_weight[i*WW +: WW] = 8'd2; in_pix[i*DW +: DW] = 12'd11; end
        end
        default: begin in_weight[i*WW +: WW] = WW'($urandom); in_pix[i*DW +: DW] = DW'($urandom); end
      endcase
    end
  endtask

  // One complete window: feed beats, wait for the result, apply backpressure,
  // consume it and confirm the input side reopens.
  task automatic run_window(input int cfg_b, input bit norm, input int wmode,
                            input int gap_pct, input int bp);
    int     eff, acc, cyc, lat;
    longint ws, ps, exp_pix, w, p;
    bit     exp_zero;
    eff = (cfg_b == 0) ? 1 : ((cfg_b > MB) ? MB : cfg_b);
    ws = 0; ps = 0; acc = 0; cyc = 0;
    while (acc < eff && cyc < 500) begin
      @(negedge clk);
      cyc++;
      drive_beat(wmode);
      in_valid = ($urandom_range(99) >= gap_pct);
      if (acc == 0) begin
        cfg_beats = CW'(cfg_b);
        cfg_norm  = norm;
      end else begin
        cfg_beats = CW'($urandom);
        cfg_norm  = 1'($urandom);
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < L; i++) begin
          w = longint'(in_weight[i*WW +: WW]);
          p = longint'(in_pix[i*DW +: DW]);
          ws += w;
          ps += w * p;
        end
        acc++;
      end
    end
    chk_eq("beats_accepted", acc, eff);
    exp_pix  = (norm && ws != 0) ? (ps + ws / 2) / ws : 0;
    exp_zero = norm && (ws == 0);

    // Keep offering beats while busy; none may be taken.
    @(negedge clk);
    drive_beat(0);
    in_valid = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk_eq("latency", lat, norm ? DW : 0);
    chk_eq("busy_in_ready", in_ready, 0);
    chk_eq("out_wsum", out_wsum, ws);
    chk_eq("out_psum", out_psum, ps);
    chk_eq("out_pix", out_pix, exp_pix);
    chk_eq("out_zero", out_zero, exp_zero);

    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk_eq("bp_out_valid", out_valid, 1);
      chk_eq("bp_in_ready", in_ready, 0);
      chk_eq("bp_out_wsum", out_wsum, ws);
      chk_eq("bp_out_pix", out_pix, exp_pix);
    end

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk_eq("post_out_valid", out_valid, 0);
    chk_eq("post_in_ready", in_ready, 1);
    chk_eq("post_out_psum_held", out_psum, ps);
  endtask

  // Accept three beats of a seven-beat window, then pulse reset.
  task automatic reset_mid_window();
    int acc, cyc;
    acc = 0; cyc = 0;
    while (acc < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      drive_beat(0);
      in_valid  = 1'b1;
      cfg_beats = 3'd7;
      cfg_norm  = 1'b1;
      if (in_valid && in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_out_valid", out_valid, 0);
    chk_eq("mid_rst_out_wsum", out_wsum, 0);
    chk_eq("mid_rst_out_psum", out_psum, 0);
    chk_eq("mid_rst_out_pix", out_pix, 0);
    chk_eq("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_beats = '0;
    cfg_norm  = 1'b0;
    in_valid  = 1'b0;
    in_weight = '0;
    in_pix    = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_out_wsum", out_wsum, 0);
    chk_eq("rst_out_psum", out_psum, 0);
    chk_eq("rst_out_pix", out_pix, 0);
    chk_eq("rst_out_zero", out_zero, 0);
    chk_eq("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    run_window(7, 1'b1, 1, 0, 0);   // full scale
    chk_eq("fs_pix_const", out_pix, 4095);
    chk_eq("fs_wsum_const", out_wsum, 12495);
    run_window(1, 1'b1, 3, 0, 0);   // rounding, normalised
    chk_eq("round_pix_const", out_pix, 11);
    run_window(1, 1'b0, 3, 0, 0);   // rounding, raw
    chk_eq("raw_psum_const", out_psum, 32);
    run_window(3, 1'b1, 2, 0, 0);   // zero weights
    chk_eq("zero_flag_const", out_zero, 1);
    run_window(5, 1'b1, 0, 0, 5);   // backpressure, normalised
    run_window(2, 1'b0, 0, 0, 5);   // backpressure, raw
    reset_mid_window();
    run_window(7, 1'b1, 0, 0, 0);   // fresh window after reset
    run_window(0, 1'b1, 0, 0, 0);   // cfg_beats 0 -> one beat
    run_window(0, 1'b0, 0, 25, 0);
    run_window(7, 1'b0, 0, 40, 1);  // gaps with max window
    run_window(7, 1'b1, 0, 40, 2);

    for (int n = 0; n < 25; n++) begin
      run_window(int'($urandom_range(7)), 1'($urandom), ($urandom_range(9) == 0) ? 1 : 0,
                 30, int'($urandom_range(3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
